// File: rtl/frame_sched_ctrl.sv
// frame_sched_ctrl: sequencer for the pseudo-sensor BRAM frame reader.
// It pulses the reader's start, watches the returned pixel stream for framing
// errors and frame completion, holds a blanking gap between frames, and walks
// a bank index through NUM_BANKS frames stored in BRAM.
// The full BRAM address is {bank, reader address}.
//
// Optional build macro: FRAME_SCHED_TIMEOUT_EN adds a RUN-state watchdog.
// Without it, err_timeout is tied low.
//
// Ports:
//   clk         system clock
//   srst        async active-high reset
//   enable      continuous mode: stream frames while high
//   single      one-cycle request for exactly one frame (one request is queued)
//   rd_start    one-cycle start pulse to the reader
//   rd_valid    reader pixel valid
//   rd_sof      reader start-of-frame
//   rd_eol      reader end-of-line
//   bank        current frame bank (upper BRAM address bits)
//   frame_cnt   completed-frame counter, wraps at 16 bits
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse at frame completion
//   err_sync    sticky framing error (sof/eol misplaced)
//   err_timeout sticky watchdog error
module frame_sched_ctrl #(
  parameter int IN_W           = 640,
  parameter int IN_H           = 480,
  parameter int NUM_BANKS      = 4,
  parameter int BB             = 2,
  parameter int GAP_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          enable,
  input  logic          single,
  output logic          rd_start,
  input  logic          rd_valid,
  input  logic          rd_sof,
  input  logic          rd_eol,
  output logic [BB-1:0] bank,
  output logic [15:0]   frame_cnt,
  output logic          busy,
  output logic          frame_done,
  output logic          err_sync,
  output logic          err_timeout
);

  // Pixel counter carries one spare bit above the frame size.
  localparam int PW = $clog2(IN_W * IN_H) + 1;
  localparam int CW = $clog2(IN_W + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [PW-1:0] PIX_LAST  = PW'(IN_W * IN_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IN_W - 1);
  localparam logic [BB-1:0] BANK_LAST = BB'(NUM_BANKS - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;

  state_t        state, state_nxt;
  logic          pending;
  logic [PW-1:0] pix;
  logic [CW-1:0] col;
  logic [GW-1:0] gap;
  logic          done_evt, to_evt, sync_bad;

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd;
`endif

  // Framing check only applies to valid pixels while RUN; stray valids
  // elsewhere are ignored.
  assign sync_bad = (state == RUN) && rd_valid &&
                    ((rd_sof != (pix == '0)) || (rd_eol != (col == COL_LAST)));

  always_comb begin
    state_nxt = state;
    done_evt  = 1'b0;
    to_evt    = 1'b0;
    case (state)
      IDLE:  if (enable || pending) state_nxt = START;
      START: state_nxt = RUN;
      RUN: begin
        if (rd_valid && (pix == PIX_LAST)) begin
          done_evt  = 1'b1;
          state_nxt = GAP;
        end
`ifdef FRAME_SCHED_TIMEOUT_EN
        // wd holds silent cycles already elapsed; this cycle is the last allowed.
        else if (!rd_valid && (wd == WD_LAST)) begin
          to_evt    = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      GAP:     if (gap == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      rd_start    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      bank        <= '0;
      frame_cnt   <= '0;
      err_sync    <= 1'b0;
      err_timeout <= 1'b0;
      pending     <= 1'b0;
      pix         <= '0;
      col         <= '0;
      gap         <= '0;
`ifdef FRAME_SCHED_TIMEOUT_EN
      wd          <= '0;
`endif
    end else begin
      // Outputs follow the next state so they line up with the state itself.
      rd_start   <= (state_nxt == START);
      busy       <= (state_nxt != IDLE);
      frame_done <= done_evt;
      err_sync   <= err_sync | sync_bad;

      // A fresh single wins over the clear, so a request arriving on the
      // consuming edge is not lost.
      pending <= single |
                 (pending & ~((state == IDLE && state_nxt == START) | to_evt));

      if (state == START) begin
        pix <= '0;
        col <= '0;
      end else if (state == RUN && rd_valid) begin
        pix <= pix + 1'b1;
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
      end

      if (done_evt) begin
        frame_cnt <= frame_cnt + 16'd1;
        bank      <= (bank == BANK_LAST) ? '0 : bank + 1'b1;
        gap       <= GAP_LOAD;
      end else if (state == GAP && gap != '0) begin
        gap <= gap - 1'b1;
      end

`ifdef FRAME_SCHED_TIMEOUT_EN
      if (state == START || (state == RUN && rd_valid)) wd <= '0;
      else if (state == RUN)                            wd <= wd + 1'b1;
      err_timeout <= err_timeout | to_evt;
`else
      err_timeout <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_frame_sched_ctrl.sv
// Directed bench for frame_sched_ctrl with a 4x2 frame, 4 banks, 3-cycle gap.
module tb_frame_sched_ctrl;
  localparam int IN_W = 4, IN_H = 2, NUM_BANKS = 4, BB = 2;
  localparam int GAP_CYCLES = 3, TIMEOUT_CYCLES = 16;
  localparam int NPIX = IN_W * IN_H;

  logic clk = 1'b0, srst = 1'b1, enable = 1'b0, single = 1'b0;
  logic rd_valid = 1'b0, rd_sof = 1'b0, rd_eol = 1'b0;
  logic rd_start, busy, frame_done, err_sync, err_timeout;
  logic [BB-1:0] bank;
  logic [15:0]   frame_cnt;

  int errors = 0, checks = 0, starts = 0, dones = 0;

  always #5 clk = ~clk;

  frame_sched_ctrl #(
    .IN_W(IN_W), .IN_H(IN_H), .NUM_BANKS(NUM_BANKS), .BB(BB),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .srst(srst), .enable(enable), .single(single),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_sof(rd_sof), .rd_eol(rd_eol),
    .bank(bank), .frame_cnt(frame_cnt), .busy(busy), .frame_done(frame_done),
    .err_sync(err_sync), .err_timeout(err_timeout)
  );

  always @(negedge clk) begin
    if (rd_start)   starts++;
    if (frame_done) dones++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (rd_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("start_seen", {31'd0, rd_start}, 1);
  endtask

  // Drives npix valid pixels with sof/eol placed correctly, except eol is
  // withheld on pixel bad_eol. enable drops from pixel drop_en; q pulses
  // single on pixels 1, 3 and 5.
  task automatic drive_frame(input int npix, input int bad_eol, input int drop_en, input bit q);
    for (int i = 0; i < npix; i++) begin
      rd_valid = 1'b1;
      rd_sof   = (i == 0);
      rd_eol   = ((i % IN_W) == IN_W - 1) && (i != bad_eol);
      single   = q && (i == 1 || i == 3 || i == 5);
      if (i == drop_en) enable = 1'b0;
      tick();
    end
    rd_valid = 1'b0; rd_sof = 1'b0; rd_eol = 1'b0; single = 1'b0;
  endtask

  initial begin
    int n, s0, d0;

    // Reset values
    tick(); tick();
    check("rst_rd_start", rd_start, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_bank", bank, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_sync", err_sync, 0);
    check("rst_err_timeout", err_timeout, 0);
    srst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Single frame: single is queued, start follows one cycle later
    single = 1'b1; tick(); single = 1'b0;
    check("single_no_early_start", rd_start, 0);
    wait_start(n);
    check("single_start_latency", n, 1);
    check("start_busy", busy, 1);
    tick();
    check("start_one_cycle", rd_start, 0);
    drive_frame(NPIX, -1, -1, 1'b0);
    check("t1_done", frame_done, 1);
    check("t1_cnt", frame_cnt, 1);
    check("t1_bank", bank, 1);
    check("t1_err_sync", err_sync, 0);
    tick();
    check("t1_done_pulse", frame_done, 0);
    tick();
    check("t1_gap_busy", busy, 1);
    tick();
    check("t1_idle_after_gap", busy, 0);
    repeat (5) tick();
    check("t1_starts", starts, 1);
    check("t1_dones", dones, 1);

    // Continuous mode: 5 frames, enable dropped mid-way through the last
    srst = 1'b1; #2; srst = 1'b0;
    check("cont_bank_rst", bank, 0);
    s0 = starts;
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_start(n);
      // Distance counted from the cycle that carried the last pixel.
      if (f > 0) check("cont_spacing", n + 1, GAP_CYCLES + 2);
      check("cont_bank", bank, f % NUM_BANKS);
      tick();
      drive_frame(NPIX, -1, (f == 4) ? 3 : -1, 1'b0);
      check("cont_done", frame_done, 1);
    end
    check("cont_cnt", frame_cnt, 5);
    check("cont_bank_wrap", bank, 1);
    repeat (12) tick();
    check("cont_starts", starts - s0, 5);
    check("cont_disable_idle", busy, 0);
    check("cont_err_sync", err_sync, 0);

    // Framing error: eol missing on pixel 3; frame still completes
    single = 1'b1; tick(); single = 1'b0;
    wait_start(n);
    tick();
    drive_frame(NPIX, 3, -1, 1'b0);
    check("ferr_err_sync", err_sync, 1);
    check("ferr_done", frame_done, 1);
    check("ferr_cnt", frame_cnt, 6);
    repeat (8) tick();
    check("ferr_sticky", err_sync, 1);
    check("ferr_idle", busy, 0);

    // Three singles during RUN queue exactly one more frame
    single = 1'b1; tick(); single = 1'b0;
    wait_start(n);
    tick();
    s0 = starts;
    d0 = dones;
    drive_frame(NPIX, -1, -1, 1'b1);
    check("q_done", frame_done, 1);
    wait_start(n);
    tick();
    drive_frame(NPIX, -1, -1, 1'b0);
    check("q_cnt", frame_cnt, 8);
    repeat (15) tick();
    check("q_starts", starts - s0, 1);
    check("q_dones", dones - d0, 2);
    check("q_idle", busy, 0);

    // Async reset mid-frame, between clock edges
    single = 1'b1; tick(); single = 1'b0;
    wait_start(n);
    tick();
    drive_frame(6, -1, -1, 1'b0);
    check("ar_busy_before", busy, 1);
    #2; srst = 1'b1; #1;
    check("ar_busy", busy, 0);
    check("ar_cnt", frame_cnt, 0);
    check("ar_bank", bank, 0);
    check("ar_err_sync", err_sync, 0);
    check("ar_rd_start", rd_start, 0);
    check("ar_frame_done", frame_done, 0);
    #1; srst = 1'b0;
    s0 = starts;
    repeat (6) tick();
    check("ar_no_restart", starts - s0, 0);
    check("ar_idle", busy, 0);

`ifdef FRAME_SCHED_TIMEOUT_EN
    // Watchdog: 3 pixels then silence; trips on the 16th silent cycle
    single = 1'b1; tick(); single = 1'b0;
    wait_start(n);
    tick();
    drive_frame(3, -1, -1, 1'b0);
    repeat (TIMEOUT_CYCLES - 1) tick();
    check("to_not_yet", err_timeout, 0);
    check("to_busy_before", busy, 1);
    tick();
    check("to_err", err_timeout, 1);
    check("to_idle", busy, 0);
    check("to_no_done", frame_done, 0);
    check("to_cnt", frame_cnt, 0);
    check("to_bank", bank, 0);
    s0 = starts;
    repeat (6) tick();
    check("to_sticky", err_timeout, 1);
    check("to_no_restart", starts - s0, 0);
`else
    // No watchdog: a stalled frame just waits in RUN
    single = 1'b1; tick(); single = 1'b0;
    wait_start(n);
    tick();
    drive_frame(3, -1, -1, 1'b0);
    repeat (TIMEOUT_CYCLES + 4) tick();
    check("nto_err", err_timeout, 0);
    check("nto_busy", busy, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
